picorv32_axil_master: RTL and testbench

Bridge between the PicoRV32 native memory interface and an AXI4-Lite master port. Converts each CPU request (read or byte-masked write) into exactly one AXI-Lite transaction, returns data/completion to the CPU, and flags slave error responses or a hung slave via a watchdog. Sits between the core and the AXI-Lite interconnect feeding peripherals such as the GPIO slave.

---
 rtl/picorv32_axil_master_pkg.sv | 35 +++
 rtl/picorv32_axil_master_if.sv | 57 +++++
 rtl/picorv32_axil_master_watchdog.sv | 31 +++
 rtl/picorv32_axil_master.sv | 184 ++++++++++++++++++
 tb/tb_picorv32_axil_master.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/picorv32_axil_master_pkg.sv
// Shared AXI4-Lite constants, bridge state encoding and error codes for the
// PicoRV32 to AXI-Lite bridge.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SLVERR  = 2'd1,
    ERR_DECERR  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  // EXOKAY carries no error for a single-beat non-exclusive access
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

  function automatic err_code_t resp_to_err(input logic [1:0] resp);
    return (resp == RESP_DECERR) ? ERR_DECERR : ERR_SLVERR;
  endfunction

endpackage

// File: rtl/picorv32_axil_master_if.sv
// CPU-side native memory interface and AXI4-Lite bus interface used by the
// PicoRV32 AXI-Lite bridge.
interface picorv32_mem_if ();
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic [1:0]  err_code;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, bus_err, err_code
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, bus_err, err_code
  );
endinterface

interface axil_if #(parameter int unsigned ADDR_WIDTH = 32) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/picorv32_axil_master_watchdog.sv
// Per-transaction watchdog: down-counter reloaded while cleared, expired on the
// TIMEOUT_CYCLES-th enabled cycle. TIMEOUT_CYCLES = 0 disables it.
module axil_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int unsigned CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned LOAD_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] LOAD = LOAD_I[CW-1:0];

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= LOAD;
    end else if (i_clr) begin
      r_cnt <= LOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired = (TIMEOUT_CYCLES != 0) && i_en && (r_cnt == '0);

endmodule

// File: rtl/picorv32_axil_master.sv
// PicoRV32 native memory port to AXI4-Lite master bridge: one AXI-Lite
// transaction per CPU request, with error reporting and a hung-slave watchdog.
//
// state           | meaning
// ST_IDLE         | waiting for mem_valid, latch request
// ST_WR_ADDR_DATA | AW and W offered together, each retires on its own handshake
// ST_WR_RESP      | waiting for B response
// ST_RD_ADDR      | AR offered until arready
// ST_RD_DATA      | waiting for R response
// ST_DONE         | one-cycle mem_ready (and bus_err on error)
module picorv32_axil_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           rst,
  picorv32_mem_if.slave mem,
  axil_if.master        axi
);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_timeout;
  logic                  w_expired;
  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [3:0]            r_wstrb;
  logic                  r_instr;
  logic                  r_aw_done;
  logic                  r_w_done;
  err_code_t             r_err_code;
  logic                  r_err_pend;
  logic                  w_awvalid;
  logic                  w_wvalid;
  logic                  w_bready;
  logic                  w_arvalid;
  logic                  w_rready;
  logic                  w_mem_ready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_resp_hs;
  logic [1:0]            w_resp;

  assign w_busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_aw_hs   = w_awvalid && axi.awready;
  assign w_w_hs    = w_wvalid && axi.wready;
  assign w_resp_hs = ((r_state == ST_WR_RESP) && axi.bvalid) ||
                     ((r_state == ST_RD_DATA) && axi.rvalid);
  assign w_resp    = (r_state == ST_WR_RESP) ? axi.bresp : axi.rresp;

  axil_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_busy),
    .i_clr     (r_state == ST_IDLE),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // A completing handshake in the expiry cycle takes priority over the abort
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem.mem_valid) w_state_next = (mem.mem_wstrb != 4'h0) ? ST_WR_ADDR_DATA : ST_RD_ADDR;
      end
      ST_WR_ADDR_DATA: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_next = ST_WR_RESP;
        else if (w_expired) begin
          w_state_next = ST_DONE;
          w_timeout    = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (axi.bvalid) w_state_next = ST_DONE;
        else if (w_expired) begin
          w_state_next = ST_DONE;
          w_timeout    = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (axi.arready) w_state_next = ST_RD_DATA;
        else if (w_expired) begin
          w_state_next = ST_DONE;
          w_timeout    = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (axi.rvalid) w_state_next = ST_DONE;
        else if (w_expired) begin
          w_state_next = ST_DONE;
          w_timeout    = 1'b1;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_mem_ready = 1'b0;
    case (r_state)
      ST_WR_ADDR_DATA: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
      end
      ST_WR_RESP: w_bready    = 1'b1;
      ST_RD_ADDR: w_arvalid   = 1'b1;
      ST_RD_DATA: w_rready    = 1'b1;
      ST_DONE:    w_mem_ready = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_instr    <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rdata    <= '0;
      r_err_code <= ERR_NONE;
      r_err_pend <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && mem.mem_valid) begin
        r_addr    <= mem.mem_addr[ADDR_WIDTH-1:0];
        r_wdata   <= mem.mem_wdata;
        r_wstrb   <= mem.mem_wstrb;
        r_instr   <= mem.mem_instr;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if ((r_state == ST_RD_DATA) && axi.rvalid) r_rdata <= axi.rdata;
      if (w_timeout && ((r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA))) r_rdata <= '1;
      r_err_pend <= 1'b0;
      if (w_timeout) begin
        r_err_code <= ERR_TIMEOUT;
        r_err_pend <= 1'b1;
      end else if (w_resp_hs && resp_is_err(w_resp)) begin
        r_err_code <= resp_to_err(w_resp);
        r_err_pend <= 1'b1;
      end
    end
  end

  assign axi.awaddr  = r_addr;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = w_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wvalid  = w_wvalid;
  assign axi.bready  = w_bready;
  assign axi.araddr  = r_addr;
  assign axi.arprot  = {r_instr, 2'b00};
  assign axi.arvalid = w_arvalid;
  assign axi.rready  = w_rready;

  assign mem.mem_ready = w_mem_ready;
  assign mem.mem_rdata = r_rdata;
  assign mem.bus_err   = w_mem_ready && r_err_pend;
  assign mem.err_code  = r_err_code;

endmodule

// File: tb/tb_picorv32_axil_master.sv
// Randomized bench for picorv32_axil_master: behavioural AXI-Lite slave with a
// word memory, plus a CPU-side reference model of memory contents and error state.
module tb_picorv32_axil_master;
  import axil_pkg::*;

  localparam int TMO = 16;

  logic clk;
  logic rst;

  picorv32_mem_if mem_bus ();
  axil_if #(.ADDR_WIDTH(32)) axi_bus ();

  picorv32_axil_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mem (mem_bus),
    .axi (axi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] slv_mem [0:15];
  logic [31:0] ref_mem [0:15];
  logic [1:0]  ref_err;

  bit          cfg_rand, cfg_w_after_aw, cfg_ar_never, cfg_b_hold;
  logic [1:0]  cfg_resp;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awprot, cap_arprot;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
    return old;
  endfunction

  function automatic bit coin();
    return !cfg_rand || ($urandom_range(0, 3) != 0);
  endfunction

  // AXI-Lite slave: sample handshakes before the edge, update drives just after it
  initial begin : slave
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, ar_got;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    logic [2:0]  p_awprot, p_arprot;
    axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.arready = 1'b0;
    axi_bus.bvalid = 1'b0; axi_bus.bresp = 2'b00;
    axi_bus.rvalid = 1'b0; axi_bus.rresp = 2'b00; axi_bus.rdata = 32'h0;
    aw_got = 0; w_got = 0; ar_got = 0;
    forever begin
      @(negedge clk);
      aw_hs = axi_bus.awvalid && axi_bus.awready;
      w_hs  = axi_bus.wvalid && axi_bus.wready;
      b_hs  = axi_bus.bvalid && axi_bus.bready;
      ar_hs = axi_bus.arvalid && axi_bus.arready;
      r_hs  = axi_bus.rvalid && axi_bus.rready;
      p_awaddr = axi_bus.awaddr; p_awprot = axi_bus.awprot;
      p_wdata = axi_bus.wdata; p_wstrb = axi_bus.wstrb;
      p_araddr = axi_bus.araddr; p_arprot = axi_bus.arprot;
      @(posedge clk); #1;
      if (rst) begin
        aw_got = 0; w_got = 0; ar_got = 0;
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.arready = 1'b0;
        axi_bus.bvalid = 1'b0; axi_bus.rvalid = 1'b0;
        continue;
      end
      if (aw_hs) begin aw_got = 1; cap_awaddr = p_awaddr; cap_awprot = p_awprot; end
      if (w_hs)  begin w_got = 1; cap_wdata = p_wdata; cap_wstrb = p_wstrb; end
      if (ar_hs) begin ar_got = 1; cap_araddr = p_araddr; cap_arprot = p_arprot; end
      if (b_hs) axi_bus.bvalid = 1'b0;
      if (r_hs) axi_bus.rvalid = 1'b0;
      if (aw_got && w_got && !axi_bus.bvalid && !cfg_b_hold && coin()) begin
        slv_mem[cap_awaddr[5:2]] = merge(slv_mem[cap_awaddr[5:2]], cap_wdata, cap_wstrb);
        axi_bus.bresp = cfg_resp; axi_bus.bvalid = 1'b1;
        aw_got = 0; w_got = 0;
      end
      if (ar_got && !axi_bus.rvalid && coin()) begin
        axi_bus.rdata = slv_mem[cap_araddr[5:2]];
        axi_bus.rresp = cfg_resp; axi_bus.rvalid = 1'b1;
        ar_got = 0;
      end
      axi_bus.awready = !aw_got && coin();
      axi_bus.wready  = !w_got && (cfg_w_after_aw ? aw_got : coin());
      axi_bus.arready = !ar_got && !cfg_ar_never && coin();
    end
  end

  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic instr, input logic [1:0] resp, input bit tmo, input int exp_lat);
    logic [31:0] exp_rdata, got_rdata;
    logic        exp_berr, got_berr;
    logic [1:0]  got_ec, first;
    logic [4:0]  quiet;
    int          idx, lat, arv;
    bit          done;
    idx = int'(addr[5:2]);
    exp_rdata = ref_mem[idx];
    if (tmo) begin
      exp_berr = 1'b1; ref_err = 2'd3; exp_rdata = 32'hFFFF_FFFF;
    end else begin
      exp_berr = (resp == RESP_SLVERR) || (resp == RESP_DECERR);
      if (resp == RESP_SLVERR) ref_err = 2'd1;
      if (resp == RESP_DECERR) ref_err = 2'd2;
      if (wstrb != 4'h0) ref_mem[idx] = merge(ref_mem[idx], wdata, wstrb);
    end
    cfg_resp = resp;
    cap_awaddr = 'x; cap_wdata = 'x; cap_wstrb = 'x; cap_araddr = 'x; cap_awprot = 'x; cap_arprot = 'x;
    @(posedge clk); #1;
    mem_bus.mem_addr = addr; mem_bus.mem_wdata = wdata; mem_bus.mem_wstrb = wstrb;
    mem_bus.mem_instr = instr; mem_bus.mem_valid = 1'b1;
    lat = 0; arv = 0; done = 0;
    got_rdata = '0; got_berr = 1'b0; got_ec = '0; quiet = '0;
    while (!done && lat < 60) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 1) begin
        first = (wstrb != 4'h0) ? {axi_bus.awvalid, axi_bus.wvalid} : {2{axi_bus.arvalid}};
        check_val("valid_next_cycle", 32'(first), 32'h3);
      end
      if (axi_bus.arvalid) arv++;
      if (mem_bus.mem_ready) begin
        done = 1; got_rdata = mem_bus.mem_rdata; got_berr = mem_bus.bus_err; got_ec = mem_bus.err_code;
        quiet = {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready};
        mem_bus.mem_valid = 1'b0;
      end
    end
    mem_bus.mem_valid = 1'b0;
    check_val("complete", 32'(done), 32'h1);
    if (done) begin
      if (exp_lat >= 0) check_val("latency", lat, exp_lat);
      check_val("bus_err", 32'(got_berr), 32'(exp_berr));
      check_val("err_code", 32'(got_ec), 32'(ref_err));
      check_val("done_quiet", 32'(quiet), 32'h0);
      if (wstrb == 4'h0) check_val("rdata", got_rdata, exp_rdata);
      if (tmo) check_val("arvalid_cycles", arv, TMO);
      else if (wstrb != 4'h0) begin
        check_val("awaddr", cap_awaddr, addr);
        check_val("awprot", 32'(cap_awprot), 32'h0);
        check_val("wdata", cap_wdata, wdata);
        check_val("wstrb", 32'(cap_wstrb), 32'(wstrb));
      end else begin
        check_val("araddr", cap_araddr, addr);
        check_val("arprot", 32'(cap_arprot), 32'({instr, 2'b00}));
      end
      @(posedge clk); @(negedge clk);
      check_val("ready_pulse", 32'(mem_bus.mem_ready), 32'h0);
    end
  endtask

  initial begin : main
    logic [31:0] a, d, w;
    logic [3:0]  s;
    logic [1:0]  r;
    bit          seen;
    rst = 1'b1;
    mem_bus.mem_valid = 1'b0; mem_bus.mem_instr = 1'b0; mem_bus.mem_addr = '0;
    mem_bus.mem_wdata = '0; mem_bus.mem_wstrb = '0;
    cfg_rand = 0; cfg_w_after_aw = 0; cfg_ar_never = 0; cfg_b_hold = 0; cfg_resp = RESP_OKAY;
    ref_err = 2'd0;
    for (int i = 0; i < 16; i++) begin
      d = $urandom; slv_mem[i] = d; ref_mem[i] = d;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctrl", 32'({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.arvalid,
                               axi_bus.rready, mem_bus.mem_ready, mem_bus.bus_err}), 32'h0);
    check_val("rst_err_code", 32'(mem_bus.err_code), 32'h0);
    check_val("rst_rdata", mem_bus.mem_rdata, 32'h0);
    check_val("rst_awaddr", axi_bus.awaddr, 32'h0);
    check_val("rst_wdata", axi_bus.wdata, 32'h0);
    rst = 1'b0;

    do_txn(32'h0000_0000, 32'hA5A5_1234, 4'hF, 1'b0, RESP_OKAY, 0, 3);
    cfg_w_after_aw = 1;
    do_txn(32'h0000_0010, 32'h1357_9BDF, 4'b0101, 1'b0, RESP_OKAY, 0, 4);
    cfg_w_after_aw = 0;
    slv_mem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
    do_txn(32'h0000_0004, 32'h0, 4'h0, 1'b1, RESP_OKAY, 0, 3);
    do_txn(32'h0000_0008, 32'h0BAD_F00D, 4'hF, 1'b0, RESP_SLVERR, 0, 3);
    do_txn(32'h0000_0008, 32'h0, 4'h0, 1'b0, RESP_OKAY, 0, 3);
    cfg_ar_never = 1;
    do_txn(32'h0000_0020, 32'h0, 4'h0, 1'b0, RESP_OKAY, 1, TMO + 1);
    cfg_ar_never = 0;

    // Reset while the bridge is parked in the write-response phase
    cfg_b_hold = 1;
    @(posedge clk); #1;
    mem_bus.mem_addr = 32'h0000_0030; mem_bus.mem_wdata = 32'hCAFE_0001;
    mem_bus.mem_wstrb = 4'hF; mem_bus.mem_instr = 1'b0; mem_bus.mem_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = axi_bus.bready;
    end
    check_val("reach_wr_resp", 32'(seen), 32'h1);
    rst = 1'b1;
    #1;
    check_val("rst_mid_ctrl", 32'({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.arvalid,
                                   axi_bus.rready, mem_bus.mem_ready, mem_bus.bus_err}), 32'h0);
    check_val("rst_mid_err_code", 32'(mem_bus.err_code), 32'h0);
    check_val("rst_mid_rdata", mem_bus.mem_rdata, 32'h0);
    mem_bus.mem_valid = 1'b0;
    cfg_b_hold = 0;
    ref_err = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_no_ready", 32'(mem_bus.mem_ready), 32'h0);
    end
    rst = 1'b0;
    do_txn(32'h0000_0030, 32'h0, 4'h0, 1'b0, RESP_OKAY, 0, 3);

    cfg_rand = 1;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      w = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      case ($urandom_range(0, 9))
        0:       r = RESP_SLVERR;
        1:       r = RESP_DECERR;
        2:       r = RESP_EXOKAY;
        default: r = RESP_OKAY;
      endcase
      do_txn(a, w, s, 1'($urandom_range(0, 1)), r, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : guard
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
